buffer_access_scheduler: RTL and testbench

- Sequencing controller in front of the shared level-handshake buffer (add/remove with add_finish/remove_finish, full/empty, index-addressed removal).
- Shares the buffer's single add port between NREQ producers with round-robin arbitration, and serves one consumer's indexed-remove requests.
- Drives the buffer's four-phase handshake from a synchronous FSM, so clients see simple one-cycle acks.

---
 rtl/buffer_sched_pkg.sv | 28 ++
 rtl/buffer_access_scheduler_rr_arbiter.sv | 34 +++
 rtl/buffer_access_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_buffer_access_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_sched_pkg.sv
// Shared definitions for the buffer access scheduler: FSM state and
// operation encodings, default widths, and a width helper.
package buffer_sched_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WIDTH  = 10;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_SIZE   = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADD_SET = 3'd1,
        ADD_CLR = 3'd2,
        REM_SET = 3'd3,
        REM_CLR = 3'd4
    } state_e;

    typedef enum logic {
        ADD = 1'b0,
        REM = 1'b1
    } op_t;

    // Index width for n requesters; never zero so single-requester builds still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_access_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr, searching cyclically, wins. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                grant_idx   = idx[IDX_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/buffer_access_scheduler.sv
// Buffer access scheduler: arbitrates NREQ producers onto the buffer's single
// add port, serves one consumer's indexed removals, and runs the buffer's
// four-phase level handshake so clients only see one-cycle ack pulses.
// Optional macro BUFFER_SCHED_TIMEOUT_EN adds a per-phase watchdog that
// aborts a stuck SET/CLR phase after TIMEOUT_CYC cycles and reports rem_err.
module buffer_access_scheduler
    import buffer_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SIZE   = DEF_SIZE
`ifdef BUFFER_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         add_req,
    input  logic [NREQ*WIDTH-1:0]   add_data,
    output logic [NREQ-1:0]         add_ack,
    input  logic                    rem_req,
    input  logic [ADDR_W-1:0]       rem_index,
    output logic                    rem_ack,
    output logic [WIDTH-1:0]        rem_data,
    output logic                    rem_err,
    output logic [ADDR_W:0]         occupancy,
    output logic [WIDTH-1:0]        buf_in,
    output logic [ADDR_W-1:0]       buf_index,
    output logic                    buf_add,
    output logic                    buf_remove,
    input  logic [WIDTH-1:0]        buf_out,
    input  logic                    buf_add_finish,
    input  logic                    buf_remove_finish,
    input  logic                    buf_full,
    input  logic                    buf_empty
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int OCC_W = ADDR_W + 1;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_ADD_SET = ADD_SET;
    localparam logic [2:0] ST_ADD_CLR = ADD_CLR;
    localparam logic [2:0] ST_REM_SET = REM_SET;
    localparam logic [2:0] ST_REM_CLR = REM_CLR;

    logic [2:0]        state_reg,      state_next;
    logic [IDX_W-1:0]  rr_ptr_reg,     rr_ptr_next;
    op_t               last_op_reg,    last_op_next;
    logic [OCC_W-1:0]  occ_reg,        occ_next;
    logic [WIDTH-1:0]  buf_in_reg,     buf_in_next;
    logic [ADDR_W-1:0] buf_index_reg,  buf_index_next;
    logic              buf_add_reg,    buf_add_next;
    logic              buf_remove_reg, buf_remove_next;
    logic [NREQ-1:0]   winner_reg,     winner_next;
    logic [NREQ-1:0]   add_ack_reg,    add_ack_next;
    logic              rem_ack_reg,    rem_ack_next;
    logic              rem_err_reg,    rem_err_next;
    logic [WIDTH-1:0]  rem_data_reg,   rem_data_next;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [WIDTH-1:0]  arb_data;

    logic add_elig;
    logic rem_in_range;
    logic rem_bad;
    logic rem_elig;

`ifdef BUFFER_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
    logic             timeout_hit;
    assign timeout_hit = (phase_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`endif

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (add_req),
        .ptr         (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign arb_data     = add_data[arb_idx*WIDTH +: WIDTH];
    assign add_elig     = arb_valid && !buf_full;
    assign rem_in_range = ({1'b0, rem_index} < occ_reg);
    assign rem_bad      = rem_req && (buf_empty || !rem_in_range);
    assign rem_elig     = rem_req && !buf_empty && rem_in_range;

    // Next-state and datapath: pick an op in IDLE, then walk the four-phase handshake.
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        last_op_next    = last_op_reg;
        occ_next        = occ_reg;
        buf_in_next     = buf_in_reg;
        buf_index_next  = buf_index_reg;
        buf_add_next    = buf_add_reg;
        buf_remove_next = buf_remove_reg;
        winner_next     = winner_reg;
        rem_data_next   = rem_data_reg;
        add_ack_next    = '0;
        rem_ack_next    = 1'b0;
        rem_err_next    = 1'b0;
`ifdef BUFFER_SCHED_TIMEOUT_EN
        phase_cnt_next  = '0;
`endif
        case (state_reg)
            ST_IDLE: begin
                // A bad remove is rejected first and blocks any add this cycle.
                if (rem_bad) begin
                    rem_err_next = 1'b1;
                end else if (add_elig && (!rem_elig || last_op_reg == REM)) begin
                    state_next   = ST_ADD_SET;
                    buf_in_next  = arb_data;
                    winner_next  = arb_grant;
                    buf_add_next = 1'b1;
                    last_op_next = ADD;
                    rr_ptr_next  = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                end else if (rem_elig) begin
                    state_next      = ST_REM_SET;
                    buf_index_next  = rem_index;
                    buf_remove_next = 1'b1;
                    last_op_next    = REM;
                end
            end
            ST_ADD_SET: begin
                if (buf_add_finish) begin
                    buf_add_next = 1'b0;
                    state_next   = ST_ADD_CLR;
                end
            end
            ST_ADD_CLR: begin
                if (!buf_add_finish) begin
                    add_ack_next = winner_reg;
                    if (occ_reg < OCC_W'(SIZE)) begin
                        occ_next = occ_reg + OCC_W'(1);
                    end
                    state_next = ST_IDLE;
                end
            end
            ST_REM_SET: begin
                if (buf_remove_finish) begin
                    rem_data_next   = buf_out;
                    buf_remove_next = 1'b0;
                    state_next      = ST_REM_CLR;
                end
            end
            ST_REM_CLR: begin
                if (!buf_remove_finish) begin
                    rem_ack_next = 1'b1;
                    if (occ_reg != '0) begin
                        occ_next = occ_reg - OCC_W'(1);
                    end
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next      = ST_IDLE;
                buf_add_next    = 1'b0;
                buf_remove_next = 1'b0;
            end
        endcase
`ifdef BUFFER_SCHED_TIMEOUT_EN
        // A phase that has not advanced either ticks its counter or is aborted.
        if (state_reg != ST_IDLE && state_next == state_reg) begin
            if (timeout_hit) begin
                state_next      = ST_IDLE;
                buf_add_next    = 1'b0;
                buf_remove_next = 1'b0;
                rem_err_next    = 1'b1;
            end else begin
                phase_cnt_next = phase_cnt_reg + CNT_W'(1);
            end
        end
`endif
    end

    // State and output registers; reset takes effect immediately, even mid-handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            last_op_reg    <= REM;
            occ_reg        <= '0;
            buf_in_reg     <= '0;
            buf_index_reg  <= '0;
            buf_add_reg    <= 1'b0;
            buf_remove_reg <= 1'b0;
            winner_reg     <= '0;
            add_ack_reg    <= '0;
            rem_ack_reg    <= 1'b0;
            rem_err_reg    <= 1'b0;
            rem_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            last_op_reg    <= last_op_next;
            occ_reg        <= occ_next;
            buf_in_reg     <= buf_in_next;
            buf_index_reg  <= buf_index_next;
            buf_add_reg    <= buf_add_next;
            buf_remove_reg <= buf_remove_next;
            winner_reg     <= winner_next;
            add_ack_reg    <= add_ack_next;
            rem_ack_reg    <= rem_ack_next;
            rem_err_reg    <= rem_err_next;
            rem_data_reg   <= rem_data_next;
        end
    end

`ifdef BUFFER_SCHED_TIMEOUT_EN
    // Per-phase watchdog counter, cleared whenever a phase is entered or left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_reg <= '0;
        end else begin
            phase_cnt_reg <= phase_cnt_next;
        end
    end
`endif

    assign add_ack    = add_ack_reg;
    assign rem_ack    = rem_ack_reg;
    assign rem_err    = rem_err_reg;
    assign rem_data   = rem_data_reg;
    assign occupancy  = occ_reg;
    assign buf_in     = buf_in_reg;
    assign buf_index  = buf_index_reg;
    assign buf_add    = buf_add_reg;
    assign buf_remove = buf_remove_reg;

endmodule

// File: tb/tb_buffer_access_scheduler.sv
// Self-checking bench: an indexed-removal buffer model with a registered
// handshake (stallable) sits behind the DUT, and a queue-based reference
// model predicts winners, removed words and occupancy.
module tb_buffer_access_scheduler;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 10;
    localparam int ADDR_W = 3;
    localparam int SIZE   = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       add_req = '0;
    logic [NREQ*WIDTH-1:0] add_data = '0;
    logic [NREQ-1:0]       add_ack;
    logic                  rem_req = 1'b0;
    logic [ADDR_W-1:0]     rem_index = '0;
    logic                  rem_ack;
    logic [WIDTH-1:0]      rem_data;
    logic                  rem_err;
    logic [ADDR_W:0]       occupancy;
    logic [WIDTH-1:0]      buf_in;
    logic [ADDR_W-1:0]     buf_index;
    logic                  buf_add;
    logic                  buf_remove;
    logic [WIDTH-1:0]      buf_out;
    logic                  buf_add_finish;
    logic                  buf_remove_finish;
    logic                  buf_full;
    logic                  buf_empty;

    int checks = 0;
    int errors = 0;

    buffer_access_scheduler #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .SIZE   (SIZE)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .add_req           (add_req),
        .add_data          (add_data),
        .add_ack           (add_ack),
        .rem_req           (rem_req),
        .rem_index         (rem_index),
        .rem_ack           (rem_ack),
        .rem_data          (rem_data),
        .rem_err           (rem_err),
        .occupancy         (occupancy),
        .buf_in            (buf_in),
        .buf_index         (buf_index),
        .buf_add           (buf_add),
        .buf_remove        (buf_remove),
        .buf_out           (buf_out),
        .buf_add_finish    (buf_add_finish),
        .buf_remove_finish (buf_remove_finish),
        .buf_full          (buf_full),
        .buf_empty         (buf_empty)
    );

    always #5 clk = ~clk;

    // ---------------- buffer model ----------------
    logic [WIDTH-1:0] bmem [0:7];
    int               bcount;
    logic             stall = 1'b0;
    logic             add_fin, rem_fin;
    logic [WIDTH-1:0] bout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcount  <= 0;
            add_fin <= 1'b0;
            rem_fin <= 1'b0;
            bout    <= '0;
        end else if (!stall) begin
            if (buf_add && !add_fin) begin
                if (bcount < 8) bmem[bcount] <= buf_in;
                bcount  <= bcount + 1;
                add_fin <= 1'b1;
            end else if (!buf_add) begin
                add_fin <= 1'b0;
            end
            if (buf_remove && !rem_fin) begin
                bout <= bmem[buf_index];
                for (int k = 0; k < 7; k++) begin
                    if (k >= int'(buf_index)) bmem[k] <= bmem[k+1];
                end
                bcount  <= bcount - 1;
                rem_fin <= 1'b1;
            end else if (!buf_remove) begin
                rem_fin <= 1'b0;
            end
        end
    end

    assign buf_out           = bout;
    assign buf_add_finish    = add_fin;
    assign buf_remove_finish = rem_fin;
    assign buf_full          = (bcount >= SIZE);
    assign buf_empty         = (bcount == 0);

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] ref_q [$];
    int               ref_ptr = 0;
    bit               saw_remove = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Interlock: the two strobes must never be high together.
    always @(negedge clk) begin
        if (rst_n) check("interlock", {31'd0, buf_add & buf_remove}, 32'd0);
        if (buf_remove) saw_remove = 1'b1;
    end

    task automatic wait_event(input int budget, output logic [NREQ-1:0] a,
                              output logic ra, output logic re, output bit ok);
        ok = 1'b0; a = '0; ra = 1'b0; re = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (add_ack != '0 || rem_ack || rem_err) begin
                a = add_ack; ra = rem_ack; re = rem_err; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        add_req = '0;
        rem_req = 1'b0;
        stall   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_q.delete();
        ref_ptr = 0;
        @(negedge clk);
    endtask

    task automatic do_add(input int p, input logic [WIDTH-1:0] d);
        logic [NREQ-1:0] a; logic ra, re; bit ok;
        add_data = NREQ*WIDTH'({$urandom(), $urandom()});
        add_data[p*WIDTH +: WIDTH] = d;
        add_req = '0;
        add_req[p] = 1'b1;
        wait_event(50, a, ra, re, ok);
        add_req = '0;
        check("add_done", {31'd0, ok}, 32'd1);
        check("add_ack", {28'd0, a}, 32'd1 << exp_winner(4'b1 << p, ref_ptr));
        check("add_no_err", {31'd0, re}, 32'd0);
        if (ok) begin
            ref_q.push_back(d);
            ref_ptr = (p + 1) % NREQ;
        end
        check("add_occ", {27'd0, occupancy}, 32'(ref_q.size()));
        $display("add producer=%0d data=%h occ=%0d", p, d, occupancy);
    endtask

    task automatic do_rem(input int idx);
        logic ra, re; bit ok, idx_seen;
        logic [WIDTH-1:0] exp_w;
        exp_w = ref_q[idx];
        rem_index = ADDR_W'(idx);
        rem_req = 1'b1;
        ok = 1'b0; ra = 1'b0; re = 1'b0; idx_seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (buf_remove && !idx_seen) begin
                idx_seen = 1'b1;
                check("rem_buf_index", {29'd0, buf_index}, 32'(idx));
            end
            if (rem_ack || rem_err) begin
                ok = 1'b1; ra = rem_ack; re = rem_err;
                break;
            end
        end
        rem_req = 1'b0;
        check("rem_done", {31'd0, ok}, 32'd1);
        check("rem_ack", {31'd0, ra}, 32'd1);
        check("rem_data", {22'd0, rem_data}, {22'd0, exp_w});
        if (ra) ref_q.delete(idx);
        check("rem_occ", {27'd0, occupancy}, 32'(ref_q.size()));
        $display("rem index=%0d data=%h occ=%0d", idx, rem_data, occupancy);
    endtask

    initial begin
        logic [NREQ-1:0] a; logic ra, re; bit ok;
        int w;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_add_ack", {28'd0, add_ack}, 32'd0);
        check("rst_rem_ack", {31'd0, rem_ack}, 32'd0);
        check("rst_rem_err", {31'd0, rem_err}, 32'd0);
        check("rst_rem_data", {22'd0, rem_data}, 32'd0);
        check("rst_occ", {27'd0, occupancy}, 32'd0);
        check("rst_strobes", {30'd0, buf_add, buf_remove}, 32'd0);
        check("rst_buf_in", {22'd0, buf_in}, 32'd0);
        check("rst_buf_index", {29'd0, buf_index}, 32'd0);
        do_reset();

        // Single add from producer 0, buf_in held stable
        add_data = '0;
        add_data[0 +: WIDTH] = 10'h005;
        add_req = 4'b0001;
        @(negedge clk);
        check("add_strobe_c1", {31'd0, buf_add}, 32'd1);
        ok = 1'b0; a = '0;
        for (int c = 0; c < 20; c++) begin
            check("buf_in_stable", {22'd0, buf_in}, 32'h005);
            @(negedge clk);
            if (add_ack != '0) begin ok = 1'b1; a = add_ack; break; end
        end
        add_req = '0;
        check("first_ack_seen", {31'd0, ok}, 32'd1);
        check("first_ack", {28'd0, a}, 32'b0001);
        @(negedge clk);
        check("first_occ", {27'd0, occupancy}, 32'd1);
        $display("add producer=0 data=005 occ=%0d", occupancy);

        // All producers held: round-robin order, saturation, full blocking
        do_reset();
        add_data = NREQ*WIDTH'({$urandom(), $urandom()});
        add_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_event(50, a, ra, re, ok);
            w = exp_winner(4'b1111, ref_ptr);
            check("rr_ack", {28'd0, a}, 32'd1 << w);
            check("rr_no_err", {31'd0, re}, 32'd0);
            ref_q.push_back(add_data[w*WIDTH +: WIDTH]);
            ref_ptr = (w + 1) % NREQ;
            $display("add producer=%0d data=%h occ=%0d", w, add_data[w*WIDTH +: WIDTH], occupancy);
            add_data = NREQ*WIDTH'({$urandom(), $urandom()});
        end
        wait_event(20, a, ra, re, ok);
        check("full_blocks", {31'd0, ok}, 32'd0);
        add_req = '0;
        check("full_occ", {27'd0, occupancy}, 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("buffer_content", {22'd0, bmem[k]}, {22'd0, ref_q[k]});
        end

        // Indexed removals, last one at index 1 with three words stored
        do_rem($urandom_range(0, 4));
        do_rem($urandom_range(0, 3));
        do_rem(1);

        // Out-of-range remove is rejected with a one-cycle error
        saw_remove = 1'b0;
        rem_index = 3'd4;
        rem_req = 1'b1;
        wait_event(10, a, ra, re, ok);
        rem_req = 1'b0;
        check("rej_err", {31'd0, re}, 32'd1);
        check("rej_no_ack", {31'd0, ra}, 32'd0);
        @(negedge clk);
        check("rej_pulse_len", {31'd0, rem_err}, 32'd0);
        repeat (3) @(negedge clk);
        check("rej_no_remove", {31'd0, saw_remove}, 32'd0);
        check("rej_occ", {27'd0, occupancy}, 32'd2);
        $display("rem index=4 rejected occ=%0d", occupancy);

        // Randomized mix of adds and removes
        for (int n = 0; n < 12; n++) begin
            if (ref_q.size() == 0 || (ref_q.size() < SIZE && $urandom_range(0, 1) == 1))
                do_add($urandom_range(0, NREQ - 1), WIDTH'($urandom()));
            else
                do_rem($urandom_range(0, ref_q.size() - 1));
        end

        // Simultaneous held add and remove: strict alternation starting with ADD
        do_reset();
        do_add(0, WIDTH'($urandom()));
        do_add(1, WIDTH'($urandom()));
        do_rem(0);
        add_data = NREQ*WIDTH'({$urandom(), $urandom()});
        add_req = 4'b0001;
        rem_index = '0;
        rem_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wait_event(50, a, ra, re, ok);
            check("alt_kind", {30'd0, (a != '0), ra}, (n % 2 == 0) ? 32'd2 : 32'd1);
            if (a != '0) begin
                ref_q.push_back(add_data[0 +: WIDTH]);
                $display("alt add data=%h occ=%0d", add_data[0 +: WIDTH], occupancy);
            end
            if (ra) begin
                check("alt_rem_data", {22'd0, rem_data}, {22'd0, ref_q[0]});
                void'(ref_q.pop_front());
                $display("alt rem data=%h occ=%0d", rem_data, occupancy);
            end
            check("alt_occ", {27'd0, occupancy}, 32'(ref_q.size()));
        end
        add_req = '0;
        rem_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset while the add strobe is held in the SET phase
        stall = 1'b1;
        add_req = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (buf_add) begin ok = 1'b1; break; end
        end
        check("stall_add_seen", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_add", {31'd0, buf_add}, 32'd0);
        check("async_rst_ack", {28'd0, add_ack}, 32'd0);
        check("async_rst_occ", {27'd0, occupancy}, 32'd0);
        $display("async reset during add set occ=%0d", occupancy);
        add_req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_q.delete();
        ref_ptr = 0;
        @(negedge clk);

        // Buffer never answers
        add_req = 4'b0001;
`ifdef BUFFER_SCHED_TIMEOUT_EN
        wait_event(40, a, ra, re, ok);
        add_req = '0;
        check("timeout_seen", {31'd0, ok}, 32'd1);
        check("timeout_err", {31'd0, re}, 32'd1);
        check("timeout_no_ack", {28'd0, a}, 32'd0);
        check("timeout_strobe", {31'd0, buf_add}, 32'd0);
        check("timeout_occ", {27'd0, occupancy}, 32'd0);
        $display("add timed out occ=%0d", occupancy);
`else
        wait_event(40, a, ra, re, ok);
        add_req = '0;
        check("stuck_no_event", {31'd0, ok}, 32'd0);
        check("stuck_strobe", {31'd0, buf_add}, 32'd1);
        $display("add waits on stuck buffer occ=%0d", occupancy);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
